// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared mode constants, product helper and configuration checks for mult_pipe_param
package mult_pkg;

  localparam logic MULT_UNSIGNED = 1'b0;
  localparam logic MULT_SIGNED   = 1'b1;

  localparam int MIN_OPW = 2;
  localparam int MAX_OPW = 32;
  localparam int MIN_PW  = 1;
  localparam int MAX_PW  = 64;
  localparam int MIN_PL  = 1;
  localparam int MAX_PL  = 4;

  // Widen a w-bit operand to 64 bits, replicating its msb when signed.
  function automatic logic [63:0] extend_operand(input logic [31:0] v, input int w,
                                                 input logic sign);
    logic [63:0] mask;
    logic [63:0] r;
    logic        msb;
    mask = (64'd1 << w) - 64'd1;
    r    = {32'd0, v} & mask;
    msb  = |({32'd0, v} & (64'd1 << (w - 1)));
    if ((sign == MULT_SIGNED) && msb) begin
      r = r | ~mask;
    end
    return r;
  endfunction

  // Low 64 bits of the extended product are exact for any operand pair up to 32x32,
  // so truncating them to wp bits gives both the modulo wrap and the sign/zero fill.
  function automatic logic [63:0] ext_product(input logic [31:0] a, input logic [31:0] b,
                                              input logic sign, input int wa, input int wb,
                                              input int wp);
    logic [63:0] full;
    logic [63:0] keep;
    full = extend_operand(a, wa, sign) * extend_operand(b, wb, sign);
    keep = (wp >= MAX_PW) ? '1 : ((64'd1 << wp) - 64'd1);
    return full & keep;
  endfunction

  function automatic bit cfg_ok(input int wa, input int wb, input int wp, input int pl);
    return (wa >= MIN_OPW) && (wa <= MAX_OPW) &&
           (wb >= MIN_OPW) && (wb <= MAX_OPW) &&
           (wp >= MIN_PW)  && (wp <= MAX_PW)  &&
           (pl >= MIN_PL)  && (pl <= MAX_PL);
  endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// rtl/mult_pipe_stage.sv - enable-gated pipeline register slice carrying valid and data
module mult_pipe_stage
  import mult_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         en,
  input  logic         valid_in,
  input  logic [W-1:0] data_in,
  output logic         valid_q,
  output logic [W-1:0] data_q
);

  // Shift on enable; a bubble moves the valid bit but keeps the last data word.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en) begin
      valid_q <= valid_in;
      if (valid_in) begin
        data_q <= data_in;
      end
    end
  end

endmodule

// File: rtl/mult_pipe_param.sv
// rtl/mult_pipe_param.sv - parametrised pipelined multiplier top; MULT_ACC_EN adds output accumulation
module mult_pipe_param
  import mult_pkg::*;
#(
  parameter int WIDTHA   = 16,
  parameter int WIDTHB   = 16,
  parameter int WIDTHP   = 32,
  parameter int PIPELINE = 2
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [WIDTHA-1:0] DataA_,
  input  logic [WIDTHB-1:0] DataB_,
  input  logic              Sign,
`ifdef MULT_ACC_EN
  input  logic              Acc_en,
  input  logic              Acc_clr,
`endif
  input  logic              In_valid,
  output logic              In_ready,
  output logic [WIDTHP-1:0] Result,
  output logic              Out_valid,
  input  logic              Out_ready
);

  // operand slice: {acc_en, acc_clr, sign, a, b}; product slices: {acc_en, acc_clr, product}
  localparam int OPW   = WIDTHA + WIDTHB + 3;
  localparam int PRW   = WIDTHP + 2;
  localparam int NCH   = (PIPELINE > 1) ? PIPELINE - 1 : 1;
  localparam int LASTI = (PIPELINE > 1) ? PIPELINE - 2 : 0;

  if (!cfg_ok(WIDTHA, WIDTHB, WIDTHP, PIPELINE)) begin : g_cfg_err
    $error("mult_pipe_param: WIDTHA/WIDTHB/WIDTHP/PIPELINE out of range");
  end

  logic              advance;
  logic              acc_en_in;
  logic              acc_clr_in;
  logic              op_v;
  logic [OPW-1:0]    op_q;
  logic              mul_valid;
  logic              mul_acc;
  logic              mul_clr;
  logic              mul_sign;
  logic [WIDTHA-1:0] mul_a;
  logic [WIDTHB-1:0] mul_b;
  logic [WIDTHP-1:0] mul_p;
  logic [WIDTHP-1:0] fin_d;
  logic              chain_v [NCH];
  logic [PRW-1:0]    chain_d [NCH];

`ifdef MULT_ACC_EN
  assign acc_en_in  = Acc_en;
  assign acc_clr_in = Acc_clr;
`else
  assign acc_en_in  = 1'b0;
  assign acc_clr_in = 1'b0;
`endif

  // The whole pipe moves together whenever the output slot is free or being drained.
  assign advance  = !Out_valid || Out_ready;
  assign In_ready = advance;

  // Multiplier sees the raw inputs in a single-stage pipe, the registered operands otherwise.
  always_comb begin
    if (PIPELINE == 1) begin
      mul_valid = In_valid;
      {mul_acc, mul_clr, mul_sign, mul_a, mul_b} =
        {acc_en_in, acc_clr_in, Sign, DataA_, DataB_};
    end else begin
      mul_valid = op_v;
      {mul_acc, mul_clr, mul_sign, mul_a, mul_b} = op_q;
    end
  end

  assign mul_p = WIDTHP'(ext_product(32'(mul_a), 32'(mul_b), mul_sign,
                                     WIDTHA, WIDTHB, WIDTHP));

  assign chain_v[0] = mul_valid;
  assign chain_d[0] = {mul_acc, mul_clr, mul_p};

  // Value loaded into the output register: plain product, or running sum when accumulating.
  always_comb begin
    fin_d = chain_d[LASTI][WIDTHP-1:0];
`ifdef MULT_ACC_EN
    if (chain_d[LASTI][WIDTHP+1]) begin
      fin_d = (chain_d[LASTI][WIDTHP] ? '0 : Result) + chain_d[LASTI][WIDTHP-1:0];
    end
`endif
  end

  if (PIPELINE == 1) begin : g_no_opnd
    assign op_v = 1'b0;
    assign op_q = '0;
  end

  for (genvar k = 0; k < PIPELINE; k++) begin : g_stage
    if (k == PIPELINE - 1) begin : g_out
      mult_pipe_stage #(.W(WIDTHP)) u_stage (
        .clk      (Clock),
        .resetn   (Reset_n),
        .en       (advance),
        .valid_in (chain_v[LASTI]),
        .data_in  (fin_d),
        .valid_q  (Out_valid),
        .data_q   (Result)
      );
    end else if (k == 0) begin : g_opnd
      mult_pipe_stage #(.W(OPW)) u_stage (
        .clk      (Clock),
        .resetn   (Reset_n),
        .en       (advance),
        .valid_in (In_valid),
        .data_in  ({acc_en_in, acc_clr_in, Sign, DataA_, DataB_}),
        .valid_q  (op_v),
        .data_q   (op_q)
      );
    end else begin : g_prod
      mult_pipe_stage #(.W(PRW)) u_stage (
        .clk      (Clock),
        .resetn   (Reset_n),
        .en       (advance),
        .valid_in (chain_v[k-1]),
        .data_in  (chain_d[k-1]),
        .valid_q  (chain_v[k]),
        .data_q   (chain_d[k])
      );
    end
  end

endmodule

// File: tb/tb_mult_pipe_param.sv
// tb/tb_mult_pipe_param.sv - randomized self-checking bench for mult_pipe_param
module tb_mult_pipe_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] a0, b0;  logic s0, iv0, ir0, ov0, or0;  logic [31:0] r0;
  logic [15:0] a1, b1;  logic s1, iv1, ir1, ov1, or1;  logic [31:0] r1;
  logic [7:0]  a2, b2;  logic s2, iv2, ir2, ov2, or2;  logic [11:0] r2;
  logic [7:0]  a3, b3;  logic s3, iv3, ir3, ov3, or3;  logic [19:0] r3;
`ifdef MULT_ACC_EN
  logic ae0, ac0;
  logic acc_off = 1'b0;
`endif

  mult_pipe_param #(.WIDTHA(16), .WIDTHB(16), .WIDTHP(32), .PIPELINE(2)) d0 (
    .Clock(clk), .Reset_n(rst_n), .DataA_(a0), .DataB_(b0), .Sign(s0),
`ifdef MULT_ACC_EN
    .Acc_en(ae0), .Acc_clr(ac0),
`endif
    .In_valid(iv0), .In_ready(ir0), .Result(r0), .Out_valid(ov0), .Out_ready(or0));

  mult_pipe_param #(.WIDTHA(16), .WIDTHB(16), .WIDTHP(32), .PIPELINE(3)) d1 (
    .Clock(clk), .Reset_n(rst_n), .DataA_(a1), .DataB_(b1), .Sign(s1),
`ifdef MULT_ACC_EN
    .Acc_en(acc_off), .Acc_clr(acc_off),
`endif
    .In_valid(iv1), .In_ready(ir1), .Result(r1), .Out_valid(ov1), .Out_ready(or1));

  mult_pipe_param #(.WIDTHA(8), .WIDTHB(8), .WIDTHP(12), .PIPELINE(1)) d2 (
    .Clock(clk), .Reset_n(rst_n), .DataA_(a2), .DataB_(b2), .Sign(s2),
`ifdef MULT_ACC_EN
    .Acc_en(acc_off), .Acc_clr(acc_off),
`endif
    .In_valid(iv2), .In_ready(ir2), .Result(r2), .Out_valid(ov2), .Out_ready(or2));

  mult_pipe_param #(.WIDTHA(8), .WIDTHB(8), .WIDTHP(20), .PIPELINE(4)) d3 (
    .Clock(clk), .Reset_n(rst_n), .DataA_(a3), .DataB_(b3), .Sign(s3),
`ifdef MULT_ACC_EN
    .Acc_en(acc_off), .Acc_clr(acc_off),
`endif
    .In_valid(iv3), .In_ready(ir3), .Result(r3), .Out_valid(ov3), .Out_ready(or3));

  // Reference: interpret operands as integers, multiply, keep wp low bits.
  function automatic logic [63:0] model(input logic [63:0] a, input int wa,
                                        input logic [63:0] b, input int wb,
                                        input logic s, input int wp);
    longint va;
    longint vb;
    logic [63:0] p;
    va = longint'(a);
    vb = longint'(b);
    if (s && (((a >> (wa - 1)) & 64'd1) != 64'd0)) va = va - (longint'(1) <<< wa);
    if (s && (((b >> (wb - 1)) & 64'd1) != 64'd0)) vb = vb - (longint'(1) <<< wb);
    p = 64'(va * vb);
    if (wp < 64) p = p & ((64'd1 << wp) - 64'd1);
    return p;
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_ov0 got %b want 0", ov0); end
    checks++; if (r0 !== 32'd0) begin errors++; $display("FAIL reset_r0 got %h want 0", r0); end
    checks++; if ({ov1, ov2, ov3} !== 3'b000) begin errors++; $display("FAIL reset_ov123 got %b want 000", {ov1, ov2, ov3}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL reset_ir0 got %b want 1", ir0); end
    checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL reset_ir1 got %b want 1", ir1); end
  endtask

  task automatic test_sign_modes();
    logic [15:0] ta [4] = '{16'hFFFD, 16'hFFFD, 16'h8000, 16'hFFFF};
    logic [15:0] tb [4] = '{16'h0007, 16'h0007, 16'h8000, 16'hFFFF};
    logic        ts [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] te [4] = '{32'hFFFFFFEB, 32'h0006FFEB, 32'h40000000, 32'hFFFE0001};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a0 = ta[i]; b0 = tb[i]; s0 = ts[i]; iv0 = 1'b1; or0 = 1'b1;
      @(negedge clk);
      iv0 = 1'b0;
      checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL sign_early_%0d got ov %b want 0", i, ov0); end
      @(negedge clk);
      checks++;
      if (ov0 !== 1'b1 || r0 !== te[i]) begin
        errors++; $display("FAIL sign_mode_%0d got ov %b res %h want ov 1 res %h", i, ov0, r0, te[i]);
      end
    end
  endtask

  task automatic test_random_stream();
    logic [63:0] q[$];
    logic [63:0] exp;
    logic        hold = 1'b0;
    logic [31:0] held = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      or0 = (c >= 360) ? 1'b1 : ($urandom_range(0, 3) != 0);
      iv0 = (c < 340) && ($urandom_range(0, 3) != 0);
      a0 = 16'($urandom); b0 = 16'($urandom); s0 = 1'($urandom);
      #1;
      if (hold) begin
        checks++;
        if (ov0 !== 1'b1 || r0 !== held) begin
          errors++; $display("FAIL stall_hold c%0d got ov %b res %h want ov 1 res %h", c, ov0, r0, held);
        end
      end
      checks++;
      if (ir0 !== (!ov0 || or0)) begin
        errors++; $display("FAIL in_ready c%0d got %b want %b", c, ir0, !ov0 || or0);
      end
      if (ov0 && or0) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stream_extra c%0d got res %h want none", c, r0);
        end else begin
          exp = q.pop_front();
          if (r0 !== 32'(exp)) begin errors++; $display("FAIL stream_data c%0d got %h want %h", c, r0, 32'(exp)); end
        end
      end
      if (iv0 && ir0) q.push_back(model(64'(a0), 16, 64'(b0), 16, s0, 32));
      hold = ov0 && !or0;
      held = r0;
    end
    iv0 = 1'b0;
    checks++; if (q.size() != 0) begin errors++; $display("FAIL stream_lost got %0d pending want 0", q.size()); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    or0 = 1'b0; iv0 = 1'b1; s0 = 1'b0; a0 = 16'd5; b0 = 16'd5;
    @(negedge clk);
    a0 = 16'd6; b0 = 16'd6;
    @(negedge clk);
    iv0 = 1'b0;
    checks++; if (ov0 !== 1'b1 || r0 !== 32'd25) begin errors++; $display("FAIL inflight got ov %b res %h want ov 1 res 19", ov0, r0); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (ov0 !== 1'b0 || r0 !== 32'd0) begin errors++; $display("FAIL mid_reset got ov %b res %h want ov 0 res 0", ov0, r0); end
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b want 1", ir0); end
    or0 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL stale_beat c%0d got ov %b res %h want ov 0", c, ov0, r0); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] want [4] = '{32'd1, 32'd4, 32'd9, 32'd16};
    int idx = 0;
    int got = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      or1 = (c >= 7);
      iv1 = (idx < 4);
      a1 = 16'(idx + 1); b1 = 16'(idx + 1); s1 = 1'b0;
      #1;
      if (c < 3) begin
        checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL bp_fill c%0d got ready %b want 1", c, ir1); end
      end else if (c < 7) begin
        checks++;
        if (ir1 !== 1'b0 || ov1 !== 1'b1 || r1 !== 32'd1) begin
          errors++; $display("FAIL bp_full c%0d got ready %b ov %b res %h want ready 0 ov 1 res 1", c, ir1, ov1, r1);
        end
      end
      if (ov1 && or1) begin
        checks++;
        if (got >= 4) begin
          errors++; $display("FAIL bp_extra got res %h want none", r1);
        end else if (r1 !== want[got]) begin
          errors++; $display("FAIL bp_order_%0d got %h want %h", got, r1, want[got]);
        end
        got++;
      end
      if (iv1 && ir1) idx++;
    end
    iv1 = 1'b0;
    checks++; if (got != 4) begin errors++; $display("FAIL bp_count got %0d want 4", got); end
  endtask

  task automatic test_width_edge();
    logic [63:0] q2[$];
    logic [63:0] q3[$];
    logic [63:0] exp;
    @(negedge clk);
    a2 = 8'h80; b2 = 8'h80; s2 = 1'b1; iv2 = 1'b1; or2 = 1'b1;
    a3 = 8'hFF; b3 = 8'h01; s3 = 1'b1; iv3 = 1'b1; or3 = 1'b1;
    @(negedge clk);
    iv2 = 1'b0; iv3 = 1'b0;
    checks++; if (ov2 !== 1'b1 || r2 !== 12'h000) begin errors++; $display("FAIL wrap12 got ov %b res %h want ov 1 res 000", ov2, r2); end
    for (int c = 0; c < 2; c++) begin
      checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL p4_early c%0d got ov %b want 0", c, ov3); end
      @(negedge clk);
    end
    checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL p4_early c2 got ov %b want 0", ov3); end
    @(negedge clk);
    checks++; if (ov3 !== 1'b1 || r3 !== 20'hFFFFF) begin errors++; $display("FAIL ext20 got ov %b res %h want ov 1 res fffff", ov3, r3); end
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      iv2 = (c < 50) && ($urandom_range(0, 4) != 0);
      iv3 = (c < 50) && ($urandom_range(0, 4) != 0);
      a2 = 8'($urandom); b2 = 8'($urandom); s2 = 1'($urandom);
      a3 = 8'($urandom); b3 = 8'($urandom); s3 = 1'($urandom);
      #1;
      if (ov2 && or2) begin
        checks++;
        exp = (q2.size() != 0) ? q2.pop_front() : 64'hDEAD;
        if (r2 !== 12'(exp)) begin errors++; $display("FAIL w12_data c%0d got %h want %h", c, r2, 12'(exp)); end
      end
      if (ov3 && or3) begin
        checks++;
        exp = (q3.size() != 0) ? q3.pop_front() : 64'hDEADBE;
        if (r3 !== 20'(exp)) begin errors++; $display("FAIL w20_data c%0d got %h want %h", c, r3, 20'(exp)); end
      end
      if (iv2 && ir2) q2.push_back(model(64'(a2), 8, 64'(b2), 8, s2, 12));
      if (iv3 && ir3) q3.push_back(model(64'(a3), 8, 64'(b3), 8, s3, 20));
    end
    iv2 = 1'b0; iv3 = 1'b0;
    checks++; if (q2.size() + q3.size() != 0) begin errors++; $display("FAIL width_lost got %0d pending want 0", q2.size() + q3.size()); end
  endtask

`ifdef MULT_ACC_EN
  task automatic test_accumulate();
    logic [15:0] ta [4] = '{16'd2, 16'd4, 16'd1, 16'd7};
    logic [15:0] tb [4] = '{16'd3, 16'd5, 16'd1, 16'd1};
    logic        te [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        tc [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] want [4] = '{32'd6, 32'd26, 32'd27, 32'd7};
    int idx = 0;
    int got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      or0 = 1'b1; iv0 = (idx < 4); s0 = 1'b0;
      a0 = ta[idx % 4]; b0 = tb[idx % 4]; ae0 = te[idx % 4]; ac0 = tc[idx % 4];
      #1;
      if (ov0 && or0) begin
        checks++;
        if (got >= 4) begin errors++; $display("FAIL acc_extra got %h want none", r0); end
        else if (r0 !== want[got]) begin errors++; $display("FAIL acc_%0d got %0d want %0d", got, r0, want[got]); end
        got++;
      end
      if (iv0 && ir0) idx++;
    end
    iv0 = 1'b0; ae0 = 1'b0; ac0 = 1'b0;
    checks++; if (got != 4) begin errors++; $display("FAIL acc_count got %0d want 4", got); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    a0 = '0; b0 = '0; s0 = 1'b0; iv0 = 1'b0; or0 = 1'b0;
    a1 = '0; b1 = '0; s1 = 1'b0; iv1 = 1'b0; or1 = 1'b0;
    a2 = '0; b2 = '0; s2 = 1'b0; iv2 = 1'b0; or2 = 1'b0;
    a3 = '0; b3 = '0; s3 = 1'b0; iv3 = 1'b0; or3 = 1'b0;
`ifdef MULT_ACC_EN
    ae0 = 1'b0; ac0 = 1'b0;
`endif
    test_reset();
    test_sign_modes();
    test_random_stream();
    test_reset_mid();
    test_backpressure();
    test_width_edge();
`ifdef MULT_ACC_EN
    test_accumulate();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
